// File: rtl/pwm_capture_if.sv
// pwm_capture_if: APB slave bus bundle for the PWM capture block.
interface pwm_capture_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    modport master (output psel, penable, pwrite, paddr, pwdata, input prdata);
    modport slave (input psel, penable, pwrite, paddr, pwdata, output prdata);
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: APB-readable period/high-time meter for a PWM input with interrupt.
// Optional glitch filter on the synchronised input when PWM_CAP_FILTER_EN is defined.
module pwm_capture #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic          apb_pclk,
    input  logic          apb_prstn,
    pwm_capture_if.slave  apb,
    input  logic          cap_in,
    output logic          cap_irq
);
    typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;
    state_t state;
    logic [SYNC_STAGES-1:0] sync;
    logic s_in, s_d, lvl, rise, fall, wr, rd, unused_ok;
    logic [2:0] ctrl, status;
    logic [CNT_W-1:0] cnt, hold_r, period, high;
    logic [7:0] addr;

    assign addr = apb.paddr[7:0];
    assign wr = apb.psel & apb.penable & apb.pwrite;
    assign rd = apb.psel & apb.penable & ~apb.pwrite;
    assign s_in = sync[SYNC_STAGES-1];
    assign rise = lvl & ~s_d;
    assign fall = ~lvl & s_d;
    assign unused_ok = &{1'b0, apb.paddr[31:8], apb.pwdata[31:3], FILT_LEN[0]};

    always_ff @(posedge apb_pclk or negedge apb_prstn)
        if (!apb_prstn) sync <= '0;
        else sync <= {sync[SYNC_STAGES-2:0], cap_in};

`ifdef PWM_CAP_FILTER_EN
    localparam int FW = $clog2(FILT_LEN + 1);
    logic [FW-1:0] fcnt;
    // Level only follows s_in after FILT_LEN consecutive disagreeing samples.
    always_ff @(posedge apb_pclk or negedge apb_prstn)
        if (!apb_prstn) begin
            lvl  <= 1'b0;
            fcnt <= '0;
        end else if (s_in == lvl) begin
            fcnt <= '0;
        end else if (fcnt == FW'(FILT_LEN - 1)) begin
            lvl  <= s_in;
            fcnt <= '0;
        end else begin
            fcnt <= fcnt + 1'b1;
        end
`else
    assign lvl = s_in;
`endif

    always_comb
        apb.prdata = !rd ? 32'h0 :
                     addr == 8'h40 ? {29'h0, ctrl} :
                     addr == 8'h44 ? 32'(period) :
                     addr == 8'h48 ? 32'(high) :
                     addr == 8'h4C ? {29'h0, status} :
                     addr == 8'h50 ? 32'(cnt) : 32'h0;

    // W1C precedes hardware sets and the CTRL write follows the one-shot clear,
    // so later non-blocking assignments give the required priorities.
    always_ff @(posedge apb_pclk or negedge apb_prstn)
        if (!apb_prstn) begin
            state   <= IDLE;
            s_d     <= 1'b0;
            ctrl    <= '0;
            status  <= '0;
            cnt     <= '0;
            hold_r  <= '0;
            period  <= '0;
            high    <= '0;
            cap_irq <= 1'b0;
        end else begin
            s_d     <= lvl;
            cap_irq <= ctrl[1] & |status;
            if (wr && addr == 8'h4C) status <= status & ~apb.pwdata[2:0];
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (ctrl[0]) state <= ARM;
                end
                ARM: begin
                    cnt <= rise ? CNT_W'(1) : '0;
                    state <= !ctrl[0] ? IDLE : rise ? MEAS : ARM;
                end
                default: begin
                    if (!ctrl[0]) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (rise) begin
                        period    <= cnt;
                        high      <= hold_r;
                        status[0] <= 1'b1;
                        if (status[0]) status[1] <= 1'b1;
                        cnt <= ctrl[2] ? '0 : CNT_W'(1);
                        if (ctrl[2]) begin
                            ctrl[0] <= 1'b0;
                            state   <= IDLE;
                        end
                    end else if (&cnt) begin
                        status[2] <= 1'b1;
                        state     <= ARM;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (fall) hold_r <= cnt;
                    end
                end
            endcase
            if (wr && addr == 8'h40) ctrl <= apb.pwdata[2:0];
        end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed self-checking bench for pwm_capture (default and 8-bit counter instances).
module tb_pwm_capture;
    logic clk = 1'b0, rstn = 1'b0, cap0 = 1'b0, cap1 = 1'b0, irq0, irq1;
    logic gen = 1'b0, gl = 1'b0;
    int total = 0, bad = 0;
    int per = 100, hi = 30, ph = 0;
    logic [31:0] d;

    pwm_capture_if ia();
    pwm_capture_if ib();
    assign ib.paddr   = ia.paddr;
    assign ib.penable = ia.penable;
    assign ib.pwrite  = ia.pwrite;
    assign ib.pwdata  = ia.pwdata;

    pwm_capture u0 (.apb_pclk(clk), .apb_prstn(rstn), .apb(ia.slave), .cap_in(cap0), .cap_irq(irq0));
    pwm_capture #(.CNT_W(8)) u1 (.apb_pclk(clk), .apb_prstn(rstn), .apb(ib.slave), .cap_in(cap1), .cap_irq(irq1));

    always #5 clk = ~clk;

    // PWM source for u0; the phase counter restarts whenever ph is reset to 0.
    initial forever begin
        @(posedge clk);
        #2;
        if (gen) begin
            cap0 = (ph < hi) || (gl && (ph == 20 || ph == 21));
            ph = (ph + 1 >= per) ? 0 : ph + 1;
        end else cap0 = 1'b0;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int s, input logic [7:0] a, input logic [31:0] v);
        ia.paddr = {24'h5A5A5A, a};
        ia.pwdata = v;
        ia.pwrite = 1'b1;
        ia.penable = 1'b0;
        if (s != 0) ib.psel = 1'b1; else ia.psel = 1'b1;
        cyc(1);
        ia.penable = 1'b1;
        cyc(1);
        ia.psel = 1'b0;
        ib.psel = 1'b0;
        ia.penable = 1'b0;
        ia.pwrite = 1'b0;
    endtask

    task automatic rd(input int s, input logic [7:0] a, output logic [31:0] v);
        ia.paddr = {24'hA5A5A5, a};
        ia.pwrite = 1'b0;
        ia.penable = 1'b0;
        if (s != 0) ib.psel = 1'b1; else ia.psel = 1'b1;
        cyc(1);
        ia.penable = 1'b1;
        #2;
        v = (s != 0) ? ib.prdata : ia.prdata;
        cyc(1);
        ia.psel = 1'b0;
        ib.psel = 1'b0;
        ia.penable = 1'b0;
    endtask

    task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", t, o, e);
        end
    endtask

    task automatic rchk(input int s, input logic [7:0] a, input logic [31:0] e, input string t);
        logic [31:0] v;
        rd(s, a, v);
        chk(t, v, e);
    endtask

    initial begin
        ia.psel = 1'b0; ib.psel = 1'b0; ia.penable = 1'b0; ia.pwrite = 1'b0;
        ia.paddr = '0; ia.pwdata = '0;
        cyc(3);
        rstn = 1'b1;
        cyc(1);
        chk("rst_irq", 32'(irq0), 32'h0);
        rchk(0, 8'h40, 32'h0, "rst_ctrl");
        rchk(0, 8'h44, 32'h0, "rst_period");
        rchk(0, 8'h4C, 32'h0, "rst_status");
        rchk(0, 8'h50, 32'h0, "rst_cnt");
        // basic measurement
        wr(0, 8'h40, 32'h1);
        rchk(0, 8'h40, 32'h1, "ctrl_rw");
        per = 100; hi = 30; ph = 0; gen = 1'b1;
        cyc(150);
        rchk(0, 8'h44, 32'd100, "period");
        rchk(0, 8'h48, 32'd30, "high");
        rchk(0, 8'h4C, 32'h1, "valid");
        rchk(0, 8'h54, 32'h0, "unmapped");
        chk("irq_disabled", 32'(irq0), 32'h0);
        rd(0, 8'h50, d);
        chk("cnt_live", 32'(d > 0 && d <= 100), 32'h1);
        // overrun and W1C
        cyc(200);
        rchk(0, 8'h4C, 32'h3, "overrun");
        gen = 1'b0;
        wr(0, 8'h4C, 32'h1);
        rchk(0, 8'h4C, 32'h2, "w1c_partial");
        wr(0, 8'h4C, 32'h3);
        rchk(0, 8'h4C, 32'h0, "w1c_all");
        // interrupt
        wr(0, 8'h40, 32'h0);
        cyc(2);
        rchk(0, 8'h50, 32'h0, "idle_cnt");
        wr(0, 8'h40, 32'h3);
        ph = 0; gen = 1'b1;
        cyc(150);
        chk("irq_set", 32'(irq0), 32'h1);
        gen = 1'b0;
        rchk(0, 8'h4C, 32'h1, "irq_status");
        wr(0, 8'h4C, 32'h1);
        chk("irq_hold", 32'(irq0), 32'h1);
        cyc(1);
        chk("irq_clr", 32'(irq0), 32'h0);
        // one-shot
        wr(0, 8'h40, 32'h0);
        wr(0, 8'h40, 32'h5);
        per = 20; hi = 5; ph = 0; gen = 1'b1;
        cyc(60);
        rchk(0, 8'h40, 32'h4, "oneshot_ctrl");
        rchk(0, 8'h44, 32'd20, "oneshot_period");
        rchk(0, 8'h48, 32'd5, "oneshot_high");
        rchk(0, 8'h4C, 32'h1, "oneshot_status");
        per = 30; hi = 10; ph = 0;
        cyc(100);
        rchk(0, 8'h44, 32'd20, "oneshot_hold");
        gen = 1'b0;
        wr(0, 8'h4C, 32'h7);
        // EN cleared mid-measurement
        wr(0, 8'h40, 32'h1);
        per = 100; hi = 30; ph = 0; gen = 1'b1;
        cyc(50);
        wr(0, 8'h40, 32'h0);
        cyc(1);
        rchk(0, 8'h50, 32'h0, "en_clr_cnt");
        rchk(0, 8'h44, 32'd20, "en_clr_keep");
        gen = 1'b0;
        // timeout on the 8-bit instance
        wr(1, 8'h40, 32'h1);
        cyc(2);
        cap1 = 1'b1;
        cyc(300);
        rchk(1, 8'h4C, 32'h4, "timeout");
        rchk(1, 8'h44, 32'h0, "timeout_period");
        wr(1, 8'h4C, 32'h4);
        rchk(1, 8'h4C, 32'h0, "timeout_clr");
        cap1 = 1'b0;
        cyc(20);
        cap1 = 1'b1;
        cyc(10);
        cap1 = 1'b0;
        cyc(40);
        cap1 = 1'b1;
        cyc(10);
        cap1 = 1'b0;
        cyc(10);
        rchk(1, 8'h44, 32'd50, "rearm_period");
        rchk(1, 8'h48, 32'd10, "rearm_high");
        rchk(1, 8'h4C, 32'h1, "rearm_status");
        chk("irq1_off", 32'(irq1), 32'h0);
        // glitches at phase 20..21 of a 40/10 signal
        wr(0, 8'h4C, 32'h7);
        wr(0, 8'h40, 32'h1);
        per = 40; hi = 10; gl = 1'b1; ph = 0; gen = 1'b1;
        cyc(150);
`ifdef PWM_CAP_FILTER_EN
        rchk(0, 8'h44, 32'd40, "glitch_period");
        rchk(0, 8'h48, 32'd10, "glitch_high");
`else
        rchk(0, 8'h44, 32'd20, "glitch_period");
`endif
        gen = 1'b0;
        gl = 1'b0;
        // asynchronous reset mid-cycle
        wr(0, 8'h40, 32'h3);
        cyc(2);
        chk("irq_pre_rst", 32'(irq0), 32'h1);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_irq", 32'(irq0), 32'h0);
        rchk(0, 8'h40, 32'h0, "async_rst_ctrl");
        rchk(0, 8'h44, 32'h0, "async_rst_period");
        rstn = 1'b1;
        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
